adc_responder: RTL and testbench

Synthesizable SPI-slave model of the board ADC: the responding end of the ADC_CS_N/ADC_SCLK/ADC_DIN/ADC_DOUT link driven by the scope's ADC controller.
- Samples the controller's pins in the system clock domain.
- Shifts in a 6-bit config word and shifts out a 12-bit result, using the same framing as the real converter.
- Results come from an internal waveform generator, so scope bring-up and closed-loop simulation run without the physical ADC.

---
 rtl/adc_responder_pkg.sv | 50 +++++
 rtl/adc_responder_if.sv | 34 +++
 rtl/adc_wavegen.sv | 61 ++++++
 rtl/adc_responder.sv | 183 ++++++++++++++++++
 tb/tb_adc_responder.sv | 344 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/adc_responder_pkg.sv
// ---------------------------------------------------------------------------
// adc_responder_pkg
// Shared types and constants for the ADC SPI-slave model:
//   - state_t        : frame sequencer states
//   - CFG_* / CH_*   : config-word layout and waveform channel numbers
//   - convert()      : turns a raw channel sample into the converter result
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

package adc_responder_pkg;

    localparam int CFG_BITS  = 6;
    localparam int DATA_BITS = 12;

    // Config word bit positions: [5] S/D, [4:2] channel, [1] UNI, [0] SLP
    localparam int CFG_SD    = 5;
    localparam int CFG_CH_HI = 4;
    localparam int CFG_CH_LO = 2;
    localparam int CFG_UNI   = 1;
    localparam int CFG_SLP   = 0;

    localparam logic [2:0] CH_RAMP  = 3'd0;
    localparam logic [2:0] CH_TRI   = 3'd1;
    localparam logic [2:0] CH_SQR   = 3'd2;
    localparam logic [2:0] CH_CONST = 3'd3;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        CONVERT
    } state_t;

    // Sleep forces zero; bipolar mode flips the MSB, turning the
    // offset-binary sample into two's complement.
    function automatic logic [DATA_BITS-1:0] convert(
        input logic [CFG_BITS-1:0]  cfg,
        input logic [DATA_BITS-1:0] raw
    );
        logic [DATA_BITS-1:0] result;
        if (cfg[CFG_SLP]) begin
            result = '0;
        end else if (cfg[CFG_UNI]) begin
            result = raw;
        end else begin
            result = raw ^ 12'h800;
        end
        return result;
    endfunction

endpackage

// File: rtl/adc_responder_if.sv
// ---------------------------------------------------------------------------
// adc_responder_if
// The four-wire ADC link between the scope's ADC controller and the
// converter (or this model of it).
//   ADC_CS_N : frame select, active low   (controller -> ADC)
//   ADC_SCLK : serial clock                (controller -> ADC)
//   ADC_DIN  : config bits, MSB first      (controller -> ADC)
//   ADC_DOUT : result bits, MSB first      (ADC -> controller)
// Modports: master = controller side, slave = converter side.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

interface adc_responder_if;

    logic ADC_CS_N;
    logic ADC_SCLK;
    logic ADC_DIN;
    logic ADC_DOUT;

    modport master (
        output ADC_CS_N,
        output ADC_SCLK,
        output ADC_DIN,
        input  ADC_DOUT
    );

    modport slave (
        input  ADC_CS_N,
        input  ADC_SCLK,
        input  ADC_DIN,
        output ADC_DOUT
    );

endinterface

// File: rtl/adc_wavegen.sv
// ---------------------------------------------------------------------------
// adc_wavegen
// Internal signal source standing in for the analog inputs. A 12-bit phase
// accumulator advances by STEP every DIV clocks; each channel derives its
// waveform from that phase.
//   clk     : system clock
//   reset   : asynchronous, active-low reset
//   channel : channel to sample (0 ramp, 1 triangle, 2 square, 3 const)
//   raw     : 12-bit unsigned sample of the selected channel
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module adc_wavegen
    import adc_responder_pkg::*;
#(
    parameter int                   DIV       = 50,
    parameter int                   STEP      = 1,
    parameter logic [DATA_BITS-1:0] CONST_VAL = 12'hA5C
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [2:0]           channel,
    output logic [DATA_BITS-1:0] raw
);

    // DIV=1 still needs a one-bit counter so the wrap compare stays legal.
    localparam int            DW       = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

    logic [DW-1:0]        divcnt;
    logic [DATA_BITS-1:0] phase;
    logic [DATA_BITS-1:0] tri_wave;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            divcnt <= '0;
            phase  <= '0;
        end else if (divcnt == DIV_LAST) begin
            divcnt <= '0;
            phase  <= phase + DATA_BITS'(STEP);
        end else begin
            divcnt <= divcnt + DW'(1);
        end
    end

    // Rises over the first half of the phase cycle, then mirrors back down.
    assign tri_wave = phase[DATA_BITS-1] ? ~{phase[DATA_BITS-2:0], 1'b0}
                                         :  {phase[DATA_BITS-2:0], 1'b0};

    always_comb begin
        raw = '0;
        case (channel)
            CH_RAMP:  raw = phase;
            CH_TRI:   raw = tri_wave;
            CH_SQR:   raw = phase[DATA_BITS-1] ? 12'hFFF : 12'h000;
            CH_CONST: raw = CONST_VAL;
            default:  raw = '0;
        endcase
    end

endmodule

// File: rtl/adc_responder.sv
// ---------------------------------------------------------------------------
// adc_responder
// SPI-slave model of the board ADC. Oversamples the controller's pins in the
// system clock domain, shifts in a 6-bit config word while shifting out the
// 12-bit result of the previous conversion, and converts at frame end.
//   clk        : system clock (50 MHz)
//   reset      : asynchronous, active-low reset
//   adc        : ADC link (slave modport)
//   cfg_word   : last committed config word
//   frame_done : one-cycle pulse when a frame ends
//   frame_err  : last frame had fewer than 12 SCLK rising edges
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module adc_responder
    import adc_responder_pkg::*;
#(
    parameter int                   DIV       = 50,
    parameter int                   STEP      = 1,
    parameter logic [DATA_BITS-1:0] CONST_VAL = 12'hA5C
) (
    input  logic                clk,
    input  logic                reset,
    adc_responder_if.slave      adc,
    output logic [CFG_BITS-1:0] cfg_word,
    output logic                frame_done,
    output logic                frame_err
);

    localparam logic [3:0] CNT_CFG  = 4'(CFG_BITS);
    localparam logic [3:0] CNT_FULL = 4'(DATA_BITS);

    // Index 0 = s1, 1 = s2, 2 = s3 (history)
    logic [2:0] cs_sync;
    logic [2:0] sclk_sync;
    logic [2:0] din_sync;

    logic cs_fall;
    logic cs_rise;
    logic sclk_rise;
    logic sclk_fall;
    logic din_bit;

    state_t state;
    state_t next_state;

    logic load_frame;
    logic take_rise;
    logic take_fall;
    logic commit;

    logic [DATA_BITS-1:0] shift_out;
    logic [DATA_BITS-1:0] result_reg;
    logic [CFG_BITS-1:0]  cfg_shift;
    logic [CFG_BITS-1:0]  eff_cfg;
    logic [3:0]           bitcnt;
    logic                 dout;
    logic [DATA_BITS-1:0] raw;

    // Synchronizers preset to the idle pin levels so that leaving reset
    // never looks like a frame start or a clock edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cs_sync   <= 3'b111;
            sclk_sync <= 3'b000;
            din_sync  <= 3'b000;
        end else begin
            cs_sync   <= {cs_sync[1:0],   adc.ADC_CS_N};
            sclk_sync <= {sclk_sync[1:0], adc.ADC_SCLK};
            din_sync  <= {din_sync[1:0],  adc.ADC_DIN};
        end
    end

    assign cs_fall   =  cs_sync[2]   & ~cs_sync[1];
    assign cs_rise   = ~cs_sync[2]   &  cs_sync[1];
    assign sclk_rise = ~sclk_sync[2] &  sclk_sync[1];
    assign sclk_fall =  sclk_sync[2] & ~sclk_sync[1];

    // DIN is taken from its history flop: the level that was settled just
    // before the SCLK rise became visible.
    assign din_bit = din_sync[2];

    // A frame with at least six rising edges carries a full config word;
    // shorter frames keep the previously committed one.
    assign eff_cfg = (bitcnt >= CNT_CFG) ? cfg_shift : cfg_word;

    adc_wavegen #(
        .DIV       (DIV),
        .STEP      (STEP),
        .CONST_VAL (CONST_VAL)
    ) u_wavegen (
        .clk     (clk),
        .reset   (reset),
        .channel (eff_cfg[CFG_CH_HI:CFG_CH_LO]),
        .raw     (raw)
    );

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (cs_fall) next_state = SHIFT;
            SHIFT:   if (cs_rise) next_state = CONVERT;
            CONVERT: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Per-state datapath strobes. CS rise outranks a coincident SCLK edge,
    // so that edge is simply not acted on.
    always_comb begin
        load_frame = 1'b0;
        take_rise  = 1'b0;
        take_fall  = 1'b0;
        commit     = 1'b0;
        frame_done = 1'b0;
        case (state)
            IDLE: begin
                load_frame = cs_fall;
            end
            SHIFT: begin
                take_rise = sclk_rise & ~cs_rise;
                take_fall = sclk_fall & ~cs_rise;
            end
            CONVERT: begin
                commit     = 1'b1;
                frame_done = 1'b1;
            end
            default: ;
        endcase
    end

    // Shift, count and conversion registers. Shifting left fills with zeros,
    // so once all 12 result bits have gone out DOUT naturally reads 0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shift_out  <= '0;
            result_reg <= '0;
            cfg_shift  <= '0;
            cfg_word   <= '0;
            bitcnt     <= '0;
            dout       <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            if (load_frame) begin
                shift_out <= result_reg;
                dout      <= result_reg[DATA_BITS-1];
                bitcnt    <= '0;
                frame_err <= 1'b0;
            end
            if (take_rise) begin
                if (bitcnt < CNT_CFG) begin
                    cfg_shift <= {cfg_shift[CFG_BITS-2:0], din_bit};
                end
                if (bitcnt != CNT_FULL) begin
                    bitcnt <= bitcnt + 4'd1;
                end
            end
            if (take_fall) begin
                shift_out <= {shift_out[DATA_BITS-2:0], 1'b0};
                dout      <= shift_out[DATA_BITS-2];
            end
            if (commit) begin
                cfg_word   <= eff_cfg;
                result_reg <= convert(eff_cfg, raw);
                frame_err  <= (bitcnt < CNT_FULL);
                dout       <= 1'b0;
            end
        end
    end

    assign adc.ADC_DOUT = dout;

endmodule

// File: tb/tb_adc_responder.sv
// ---------------------------------------------------------------------------
// tb_adc_responder
// Self-checking bench for adc_responder. Acts as the ADC controller on the
// link, keeps a behavioural model of the converter (committed config and
// pending result) and compares every frame's read-back, status and config.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_adc_responder;

    localparam int HALF = 5;   // clk cycles per SCLK half period

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] cfg_word;
    logic       frame_done;
    logic       frame_err;

    adc_responder_if bus();

    adc_responder #(
        .DIV       (1),
        .STEP      (1),
        .CONST_VAL (12'hA5C)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .adc        (bus),
        .cfg_word   (cfg_word),
        .frame_done (frame_done),
        .frame_err  (frame_err)
    );

    always #10 clk = ~clk;

    int vectors    = 0;
    int miscompares = 0;
    int done_cnt   = 0;
    int cyc        = 0;
    int rise_cyc   = 0;

    always @(posedge clk) cyc++;
    always @(negedge clk) if (frame_done === 1'b1) done_cnt++;

    // Model of the converter: committed config, next result, and whether
    // that result is predictable (channels 0..2 depend on the free-running
    // phase and are only checked by differences).
    logic [5:0]  m_cfg;
    logic [11:0] m_result;
    bit          m_known;

    function automatic int model_value(input logic [5:0] cfg);
        int v;
        if (cfg[0]) return 0;
        v = (cfg[4:2] == 3'd3) ? 'hA5C : 0;
        if (!cfg[1]) v = (v + 2048) % 4096;
        return v;
    endfunction

    function automatic logic [15:0] expect_read(input int nsclk);
        logic [15:0] word;
        word = {m_result, 4'h0};
        if (nsclk >= 16) return word;
        return word & ~(16'hFFFF >> nsclk);
    endfunction

    task automatic model_frame(input logic [5:0] cfg, input int nsclk, output logic exp_err);
        exp_err = (nsclk < 12);
        if (nsclk >= 6) m_cfg = cfg;
        if (!m_cfg[0] && m_cfg[4:2] < 3'd3) begin
            m_known = 1'b0;
        end else begin
            m_known  = 1'b1;
            m_result = 12'(model_value(m_cfg));
        end
    endtask

    // One controller frame: CS low, nsclk SCLK pulses with the config on DIN,
    // DOUT sampled just before each rising edge, then CS high.
    task automatic do_frame(input logic [5:0] cfg, input int nsclk,
                            input bit cs_on_fall, output logic [15:0] rd);
        rd = '0;
        @(negedge clk);
        bus.ADC_CS_N = 1'b0;
        bus.ADC_DIN  = cfg[5];
        for (int i = 0; i < nsclk; i++) begin
            repeat (HALF) @(negedge clk);
            if (i < 16) rd[15-i] = bus.ADC_DOUT;
            bus.ADC_SCLK = 1'b1;
            repeat (HALF) @(negedge clk);
            bus.ADC_SCLK = 1'b0;
            if (i + 1 < 6) bus.ADC_DIN = cfg[4-i];
            else           bus.ADC_DIN = 1'($urandom_range(0, 1));
        end
        if (!(cs_on_fall && nsclk > 0)) repeat (HALF) @(negedge clk);
        bus.ADC_CS_N = 1'b1;
        rise_cyc = cyc;
        repeat (8) @(negedge clk);
    endtask

    task automatic test_reset();
        bus.ADC_CS_N = 1'b1;
        bus.ADC_SCLK = 1'b0;
        bus.ADC_DIN  = 1'b0;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if (bus.ADC_DOUT !== 1'b0 || cfg_word !== 6'd0 || frame_done !== 1'b0 || frame_err !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_state: dout=%b cfg=%b done=%b err=%b, expected all 0",
                     bus.ADC_DOUT, cfg_word, frame_done, frame_err);
        end
        reset = 1'b1;
        m_cfg = '0; m_result = '0; m_known = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    // Config words, bipolar/unipolar, short frames and sleep.
    task automatic test_config_words();
        logic [5:0]  cfgs [7]  = '{6'b001110, 6'b001110, 6'b001100, 6'b001100,
                                  6'b001111, 6'b001110, 6'b001110};
        int          lens [7]  = '{12, 12, 12, 12, 8, 4, 12};
        logic [15:0] rd, exp_rd;
        logic        exp_err;
        bit          known;
        int          d0;
        for (int k = 0; k < 7; k++) begin
            exp_rd = expect_read(lens[k]);
            known  = m_known;
            d0     = done_cnt;
            do_frame(cfgs[k], lens[k], 1'b0, rd);
            model_frame(cfgs[k], lens[k], exp_err);
            if (known) begin
                vectors++;
                if (rd !== exp_rd) begin
                    miscompares++;
                    $display("[TB] FAIL cfg_read[%0d]: got %h expected %h", k, rd, exp_rd);
                end
            end
            vectors++;
            if (done_cnt - d0 !== 1) begin
                miscompares++;
                $display("[TB] FAIL cfg_done[%0d]: got %0d pulses expected 1", k, done_cnt - d0);
            end
            vectors++;
            if (frame_err !== exp_err) begin
                miscompares++;
                $display("[TB] FAIL cfg_err[%0d]: got %b expected %b", k, frame_err, exp_err);
            end
            vectors++;
            if (cfg_word !== m_cfg) begin
                miscompares++;
                $display("[TB] FAIL cfg_word[%0d]: got %b expected %b", k, cfg_word, m_cfg);
            end
        end
    endtask

    // Random config words on the predictable channels, random frame lengths.
    task automatic test_random();
        int          len_tab [9] = '{0, 3, 5, 6, 8, 11, 12, 14, 16};
        logic [5:0]  cfg;
        logic [15:0] rd, exp_rd;
        logic        exp_err;
        bit          known, fall;
        int          n, d0;
        for (int k = 0; k < 24; k++) begin
            cfg  = {1'($urandom_range(0, 1)), 3'($urandom_range(3, 7)), 2'($urandom_range(0, 3))};
            n    = len_tab[$urandom_range(0, 8)];
            fall = 1'($urandom_range(0, 1));
            exp_rd = expect_read(n);
            known  = m_known;
            d0     = done_cnt;
            do_frame(cfg, n, fall, rd);
            model_frame(cfg, n, exp_err);
            if (known) begin
                vectors++;
                if (rd !== exp_rd) begin
                    miscompares++;
                    $display("[TB] FAIL rand_read[%0d] n=%0d: got %h expected %h", k, n, rd, exp_rd);
                end
            end
            vectors++;
            if (done_cnt - d0 !== 1) begin
                miscompares++;
                $display("[TB] FAIL rand_done[%0d]: got %0d pulses expected 1", k, done_cnt - d0);
            end
            vectors++;
            if (frame_err !== exp_err) begin
                miscompares++;
                $display("[TB] FAIL rand_err[%0d] n=%0d: got %b expected %b", k, n, frame_err, exp_err);
            end
            vectors++;
            if (cfg_word !== m_cfg) begin
                miscompares++;
                $display("[TB] FAIL rand_cfg[%0d] n=%0d: got %b expected %b", k, n, cfg_word, m_cfg);
            end
        end
    endtask

    // Over-long frames and CS rising together with the last SCLK fall.
    task automatic test_long_frames();
        logic [5:0]  cfgs [5] = '{6'b001110, 6'b001110, 6'b001110, 6'b001100, 6'b001100};
        int          lens [5] = '{16, 16, 12, 14, 12};
        bit          falls[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        logic [15:0] rd, exp_rd;
        logic        exp_err;
        bit          known;
        int          d0;
        for (int k = 0; k < 5; k++) begin
            exp_rd = expect_read(lens[k]);
            known  = m_known;
            d0     = done_cnt;
            do_frame(cfgs[k], lens[k], falls[k], rd);
            model_frame(cfgs[k], lens[k], exp_err);
            if (known) begin
                vectors++;
                if (rd !== exp_rd) begin
                    miscompares++;
                    $display("[TB] FAIL long_read[%0d]: got %h expected %h", k, rd, exp_rd);
                end
            end
            vectors++;
            if (done_cnt - d0 !== 1) begin
                miscompares++;
                $display("[TB] FAIL long_done[%0d]: got %0d pulses expected 1", k, done_cnt - d0);
            end
            vectors++;
            if (frame_err !== exp_err) begin
                miscompares++;
                $display("[TB] FAIL long_err[%0d]: got %b expected %b", k, frame_err, exp_err);
            end
            vectors++;
            if (cfg_word !== m_cfg) begin
                miscompares++;
                $display("[TB] FAIL long_cfg[%0d]: got %b expected %b", k, cfg_word, m_cfg);
            end
        end
    endtask

    // Ramp channel: conversions 1000 clocks apart must differ by 1000 steps.
    task automatic test_phase_step();
        logic [15:0] rd;
        logic [11:0] prev, cur;
        int          target, guard, d;
        do_frame(6'b000010, 12, 1'b0, rd);
        do_frame(6'b000010, 12, 1'b0, rd);
        for (int k = 0; k < 3; k++) begin
            target = rise_cyc + 1000 - (12 * 2 * HALF + HALF) - 1;
            guard  = 0;
            while (cyc < target && guard < 2000) begin
                @(negedge clk);
                guard++;
            end
            do_frame(6'b000010, 12, 1'b0, rd);
            cur = rd[15:4];
            if (k > 0) begin
                d = (int'(cur) - int'(prev) + 4096) % 4096;
                vectors++;
                if (d < 999 || d > 1001) begin
                    miscompares++;
                    $display("[TB] FAIL ramp_step[%0d]: got delta %0d expected 1000 +/-1 (%h -> %h)",
                             k, d, prev, cur);
                end
            end
            prev = cur;
        end
        m_cfg = 6'b000010;
        m_known = 1'b0;
    endtask

    // Reset in the middle of a frame, then SCLK activity with CS idle.
    task automatic test_reset_mid_frame();
        logic [15:0] rd;
        int          d0;
        do_frame(6'b001110, 12, 1'b0, rd);
        @(negedge clk);
        bus.ADC_CS_N = 1'b0;
        for (int i = 0; i < 5; i++) begin
            repeat (HALF) @(negedge clk);
            bus.ADC_SCLK = 1'b1;
            repeat (HALF) @(negedge clk);
            bus.ADC_SCLK = 1'b0;
        end
        repeat (HALF) @(negedge clk);
        vectors++;
        if (bus.ADC_DOUT !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL midframe_bit6: got %b expected 1", bus.ADC_DOUT);
        end
        reset = 1'b0;
        #1;
        vectors++;
        if (bus.ADC_DOUT !== 1'b0 || cfg_word !== 6'd0 || frame_err !== 1'b0 || frame_done !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL midframe_reset: dout=%b cfg=%b err=%b done=%b expected all 0",
                     bus.ADC_DOUT, cfg_word, frame_err, frame_done);
        end
        bus.ADC_CS_N = 1'b1;
        bus.ADC_SCLK = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        m_cfg = '0; m_result = '0; m_known = 1'b1;
        d0 = done_cnt;
        for (int i = 0; i < 16; i++) begin
            repeat (HALF) @(negedge clk);
            bus.ADC_SCLK = ~bus.ADC_SCLK;
            vectors++;
            if (bus.ADC_DOUT !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL idle_sclk_dout[%0d]: got %b expected 0", i, bus.ADC_DOUT);
            end
        end
        repeat (HALF) @(negedge clk);
        vectors++;
        if (done_cnt !== d0) begin
            miscompares++;
            $display("[TB] FAIL idle_sclk_done: got %0d pulses expected 0", done_cnt - d0);
        end
        do_frame(6'b001110, 12, 1'b0, rd);
        vectors++;
        if (rd !== 16'h0000) begin
            miscompares++;
            $display("[TB] FAIL post_reset_read: got %h expected 0000", rd);
        end
    endtask

    initial begin
        #2ms;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_config_words();
        test_random();
        test_long_frames();
        test_phase_step();
        test_reset_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
